// File: rtl/fifo2w.sv
// fifo2w: circular-buffer FIFO that accepts up to two enqueues and two
// dequeues per clock. It tracks occupancy and free slots. A producer offer
// or consumer request that exceeds what the queue can take is only partly
// accepted. Flush empties the queue in one cycle, for use in pipeline
// recovery.
`timescale 1ns/1ps

module fifo2w #(
    parameter int SIZE  = 5,
    parameter int WIDTH = 16,
    parameter int DEBUG = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       push_cnt,
    input  logic [WIDTH-1:0] data_in0,
    input  logic [WIDTH-1:0] data_in1,
    output logic [1:0]       push_acc,
    input  logic [1:0]       pop_cnt,
    output logic [1:0]       pop_acc,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic [1:0]       out_vld,
    input  logic             flush,
    output logic [SIZE:0]    count,
    output logic [SIZE:0]    free,
    output logic             q_full,
    output logic             q_empty
);

    localparam int            D     = 1 << SIZE;
    localparam logic [SIZE:0] DEPTH = (SIZE+1)'(D);

    // Reject configurations the pointer arithmetic cannot support.
    if (SIZE < 1 || (DEBUG != 0 && DEBUG != 1)) begin : g_bad_param
        $error("fifo2w: SIZE must be >= 1 and DEBUG must be 0 or 1");
    end

    logic [WIDTH-1:0] mem [D];
    logic [SIZE-1:0]  head;
    logic [SIZE-1:0]  tail;

    // A request code of 3 is treated as 2.
    function automatic logic [1:0] clamp_req(input logic [1:0] req);
        return (req == 2'd3) ? 2'd2 : req;
    endfunction

    // Grant min(req, avail). When avail < req (req <= 2), avail is 0 or 1.
    function automatic logic [1:0] grant(input logic [1:0] req, input logic [SIZE:0] avail);
        if ((SIZE+1)'(req) <= avail)
            return req;
        else
            return (avail == '0) ? 2'd0 : 2'd1;
    endfunction

    // Acceptance is decided from the start-of-cycle count. Slots freed by
    // this cycle's pop are not reused until the next cycle. A push into an
    // empty queue cannot be popped in the same cycle.
    always_comb begin
        free     = DEPTH - count;
        push_acc = 2'd0;
        pop_acc  = 2'd0;
        if (!flush) begin
            push_acc = grant(clamp_req(push_cnt), DEPTH - count);
            pop_acc  = grant(clamp_req(pop_cnt), count);
        end
    end

    assign q_full  = (count == DEPTH);
    assign q_empty = (count == '0) || flush;

    // Storage write: only accepted entries land in the array. The index
    // wraps naturally at D.
    always_ff @(posedge clk) begin
        if (push_acc != 2'd0)
            mem[tail] <= data_in0;
        if (push_acc == 2'd2)
            mem[tail + SIZE'(1)] <= data_in1;
    end

    // Read stage: the dequeued words are registered from pre-update contents.
    // They hold their value on cycles with no pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out0 <= '0;
            data_out1 <= '0;
        end else if (pop_acc != 2'd0) begin
            data_out0 <= mem[head];
            data_out1 <= mem[head + SIZE'(1)];
        end
    end

    // Pointer, occupancy and output-valid bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            out_vld <= 2'd0;
        end else if (flush) begin
            head    <= tail;
            count   <= '0;
            out_vld <= 2'd0;
        end else begin
            head    <= head + SIZE'(pop_acc);
            tail    <= tail + SIZE'(push_acc);
            count   <= count + (SIZE+1)'(push_acc) - (SIZE+1)'(pop_acc);
            out_vld <= pop_acc;
        end
    end

endmodule

// File: tb/tb_fifo2w.sv
// tb_fifo2w: directed scenarios followed by randomized traffic. A queue
// model checks fifo2w (SIZE=2, D=4, WIDTH=16) every cycle.
`timescale 1ns/1ps

module tb_fifo2w;

    localparam int SIZE  = 2;
    localparam int WIDTH = 16;
    localparam int D     = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       push_cnt = 2'd0;
    logic [WIDTH-1:0] data_in0 = '0;
    logic [WIDTH-1:0] data_in1 = '0;
    logic [1:0]       push_acc;
    logic [1:0]       pop_cnt = 2'd0;
    logic [1:0]       pop_acc;
    logic [WIDTH-1:0] data_out0;
    logic [WIDTH-1:0] data_out1;
    logic [1:0]       out_vld;
    logic             flush = 1'b0;
    logic [SIZE:0]    count;
    logic [SIZE:0]    free;
    logic             q_full;
    logic             q_empty;

    int checks = 0;
    int failures = 0;

    fifo2w #(.SIZE(SIZE), .WIDTH(WIDTH), .DEBUG(0)) dut (
        .clk(clk), .reset(reset),
        .push_cnt(push_cnt), .data_in0(data_in0), .data_in1(data_in1), .push_acc(push_acc),
        .pop_cnt(pop_cnt), .pop_acc(pop_acc),
        .data_out0(data_out0), .data_out1(data_out1), .out_vld(out_vld),
        .flush(flush), .count(count), .free(free), .q_full(q_full), .q_empty(q_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // Number granted: request (3 counts as 2) limited by availability.
    function automatic int grant(input int req, input int avail);
        int r;
        r = (req == 3) ? 2 : req;
        return (r < avail) ? r : avail;
    endfunction

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_d0, exp_d1;
    int               exp_vld = 0;
    bit               exp_dz = 1'b0;
    bit               live = 1'b0;

    always @(posedge clk) begin
        int pa, pp;
        if (reset) begin
            q.delete();
            exp_vld = 0;
            exp_d0  = '0;
            exp_d1  = '0;
            exp_dz  = 1'b1;
            live    = 1'b1;
        end else if (live) begin
            if (flush) begin
                q.delete();
                exp_vld = 0;
            end else begin
                pa = grant(int'(push_cnt), D - q.size());
                pp = grant(int'(pop_cnt), q.size());
                if (pp >= 1) begin
                    exp_d0 = q.pop_front();
                    exp_dz = 1'b0;
                end
                if (pp == 2) exp_d1 = q.pop_front();
                exp_vld = pp;
                if (pa >= 1) q.push_back(data_in0);
                if (pa == 2) q.push_back(data_in1);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int sz;
        if (live) begin
            sz = q.size();
            chk("push_acc", 32'(push_acc), flush ? 0 : grant(int'(push_cnt), D - sz));
            chk("pop_acc",  32'(pop_acc),  flush ? 0 : grant(int'(pop_cnt), sz));
            chk("count",    32'(count),    sz);
            chk("free",     32'(free),     D - sz);
            chk("q_full",   32'(q_full),   (sz == D) ? 1 : 0);
            chk("q_empty",  32'(q_empty),  (sz == 0 || flush) ? 1 : 0);
            chk("out_vld",  32'(out_vld),  exp_vld);
            if (exp_vld >= 1 || exp_dz) chk("data_out0", 32'(data_out0), 32'(exp_d0));
            if (exp_vld == 2 || exp_dz) chk("data_out1", 32'(data_out1), 32'(exp_d1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic f, input logic [1:0] pc,
                       input logic [15:0] a, input logic [15:0] b, input logic [1:0] oc);
        @(posedge clk);
        #2;
        reset = r; flush = f; push_cnt = pc; data_in0 = a; data_in1 = b; pop_cnt = oc;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic r, f;
        logic [1:0] pc, oc;

        // Reset values
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_rst_count", 32'(count), 0);
        chk("lit_rst_empty", 32'(q_empty), 1);
        chk("lit_rst_vld", 32'(out_vld), 0);
        chk("lit_rst_d0", 32'(data_out0), 0);
        chk("lit_rst_d1", 32'(data_out1), 0);
        chk("lit_rst_free", 32'(free), 4);

        // Fill to full, rejected push, pop two
        cyc(0, 0, 2, 16'hA, 16'hB, 0);
        chk("lit_push_ab", 32'(push_acc), 2);
        cyc(0, 0, 2, 16'hC, 16'hD, 0);
        cyc(0, 0, 1, 16'hE, 16'h0, 0);
        chk("lit_full", 32'(q_full), 1);
        chk("lit_full_count", 32'(count), 4);
        chk("lit_full_pushacc", 32'(push_acc), 0);
        cyc(0, 0, 0, 0, 0, 2);
        chk("lit_pop2_acc", 32'(pop_acc), 2);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_pop2_vld", 32'(out_vld), 2);
        chk("lit_pop2_d0", 32'(data_out0), 32'hA);
        chk("lit_pop2_d1", 32'(data_out1), 32'hB);
        chk("lit_pop2_count", 32'(count), 2);
        cyc(0, 0, 0, 0, 0, 2);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_drain_d0", 32'(data_out0), 32'hC);
        chk("lit_drain_d1", 32'(data_out1), 32'hD);

        // Wrap-around: tail at 3 when pushing a pair
        cyc(0, 0, 2, 16'h1, 16'h2, 0);
        cyc(0, 0, 1, 16'h3, 16'h0, 0);
        cyc(0, 0, 0, 0, 0, 2);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 2, 16'h4, 16'h5, 0);
        chk("lit_wrap_pushacc", 32'(push_acc), 2);
        cyc(0, 0, 0, 0, 0, 2);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_wrap_d0", 32'(data_out0), 32'h4);
        chk("lit_wrap_d1", 32'(data_out1), 32'h5);

        // Partial acceptance with one free slot
        cyc(0, 0, 2, 16'h11, 16'h12, 0);
        cyc(0, 0, 1, 16'h13, 16'h0, 0);
        cyc(0, 0, 2, 16'h58, 16'h59, 0);
        chk("lit_partial_acc", 32'(push_acc), 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_partial_count", 32'(count), 4);
        cyc(0, 0, 0, 0, 0, 2);
        cyc(0, 0, 0, 0, 0, 2);
        chk("lit_partial_d0a", 32'(data_out0), 32'h11);
        chk("lit_partial_d1a", 32'(data_out1), 32'h12);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_partial_d0b", 32'(data_out0), 32'h13);
        chk("lit_partial_d1b", 32'(data_out1), 32'h58);

        // No bypass: push and pop into an empty queue
        cyc(0, 0, 1, 16'hF0, 16'h0, 1);
        chk("lit_nobypass_popacc", 32'(pop_acc), 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_nobypass_vld", 32'(out_vld), 0);
        chk("lit_nobypass_count", 32'(count), 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_nobypass_d0", 32'(data_out0), 32'hF0);

        // Flush with a simultaneous push and pop, then reset mid-burst
        cyc(0, 0, 2, 16'h21, 16'h22, 0);
        cyc(0, 0, 1, 16'h23, 16'h0, 0);
        cyc(0, 1, 2, 16'h24, 16'h25, 2);
        chk("lit_flush_pushacc", 32'(push_acc), 0);
        chk("lit_flush_popacc", 32'(pop_acc), 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_flush_count", 32'(count), 0);
        chk("lit_flush_vld", 32'(out_vld), 0);
        cyc(0, 0, 2, 16'h31, 16'h32, 0);
        cyc(1, 0, 2, 16'h33, 16'h34, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_rst2_count", 32'(count), 0);
        chk("lit_rst2_vld", 32'(out_vld), 0);
        chk("lit_rst2_d0", 32'(data_out0), 0);
        chk("lit_rst2_d1", 32'(data_out1), 0);
        chk("lit_rst2_free", 32'(free), 4);

        // Randomized traffic with fill-biased and drain-biased phases
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 127) == 0);
            f  = ($urandom_range(0, 39) == 0);
            pc = 2'($urandom_range(0, 3));
            oc = 2'($urandom_range(0, 3));
            if ((i / 150) % 2 == 0) oc = 2'($urandom_range(0, 1));
            else                    pc = 2'($urandom_range(0, 1));
            cyc(r, f, pc, 16'($urandom), 16'($urandom), oc);
        end
        cyc(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
